// File: rtl/fetch_pc_controller_if.sv
// Fetch-stage PC control bundle: hazard/redirect inputs, imem handshake,
// and the PC / IF-ID register controls driven back by the controller.
interface fetch_pc_controller_if;
  logic [31:0] pc_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        trap_i;
  logic        imem_ready_i;
  logic        pc_write_o;
  logic [31:0] pc_next_o;
  logic        imem_req_o;
  logic        if_id_write_o;
  logic        if_id_flush_o;
  logic        pending_o;

  // Controller side
  modport slave (
    input  pc_i, stall_i, branch_taken_i, branch_target_i, jump_i,
           jump_target_i, trap_i, imem_ready_i,
    output pc_write_o, pc_next_o, imem_req_o, if_id_write_o,
           if_id_flush_o, pending_o
  );

  // Pipeline / environment side
  modport master (
    output pc_i, stall_i, branch_taken_i, branch_target_i, jump_i,
           jump_target_i, trap_i, imem_ready_i,
    input  pc_write_o, pc_next_o, imem_req_o, if_id_write_o,
           if_id_flush_o, pending_o
  );
endinterface

// File: rtl/fetch_pc_controller.sv
// Fetch-stage program counter sequencer.
// Chooses the next PC (sequential / branch / jump / trap), honours load-use
// stalls, and parks a redirect while instruction memory is not ready so the
// redirect is applied on the first ready cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | one cycle after reset release, loads RESET_VECTOR
// FETCH | normal fetch, sequential advance or immediate redirect
// WAIT  | fetch outstanding, memory not ready, no redirect held
// PEND  | redirect latched in pend_target, waiting for memory ready
module fetch_pc_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  res,
  fetch_pc_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    PEND  = 2'd3
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_flush_q, pend_flush_d;
  // Remembers that the parked redirect is a trap so a later branch/jump
  // (lower priority) cannot overwrite it.
  logic        pend_trap_q, pend_trap_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_seq;
  logic        pend_take_new;

  logic        pc_write;
  logic [31:0] pc_next;
  logic        imem_req;
  logic        if_id_write;
  logic        if_id_flush;
  logic        pending;

  // Redirect source selection: trap, then jump, then branch; word aligned
  always_comb begin
    redirect = bus.trap_i | bus.jump_i | bus.branch_taken_i;
    if (bus.trap_i) begin
      redirect_target = TRAP_VECTOR & ALIGN_MASK;
    end else if (bus.jump_i) begin
      redirect_target = bus.jump_target_i & ALIGN_MASK;
    end else begin
      redirect_target = bus.branch_target_i & ALIGN_MASK;
    end
  end

  assign pc_seq = bus.pc_i + 32'd4;

  // A fresh redirect replaces the parked one unless it would demote a trap
  assign pend_take_new = redirect & (bus.trap_i | ~pend_trap_q);

  // State and pending-redirect registers
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q       <= BOOT;
      pend_target_q <= 32'h0000_0000;
      pend_flush_q  <= 1'b0;
      pend_trap_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      pend_flush_q  <= pend_flush_d;
      pend_trap_q   <= pend_trap_d;
    end
  end

  // Next-state and output decode; reset forces outputs immediately
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    pend_flush_d  = pend_flush_q;
    pend_trap_d   = pend_trap_q;
    pc_write      = 1'b0;
    pc_next       = pc_seq;
    imem_req      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    pending       = 1'b0;

    case (state_q)
      BOOT: begin
        pc_write    = 1'b1;
        pc_next     = RESET_VECTOR;
        if_id_flush = 1'b1;
        state_d     = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          if_id_flush = 1'b1;
          if (bus.imem_ready_i) begin
            pc_write    = 1'b1;
            pc_next     = redirect_target;
            if_id_write = 1'b1;
          end else begin
            pend_target_d = redirect_target;
            pend_flush_d  = 1'b1;
            pend_trap_d   = bus.trap_i;
            state_d       = PEND;
          end
        end else if (bus.stall_i) begin
          // hold PC and IF/ID; nothing to do
        end else if (bus.imem_ready_i) begin
          pc_write    = 1'b1;
          pc_next     = pc_seq;
          if_id_write = 1'b1;
        end else begin
          if_id_flush = 1'b1;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        imem_req    = 1'b1;
        if_id_flush = 1'b1;
        if (redirect) begin
          pend_target_d = redirect_target;
          pend_flush_d  = 1'b1;
          pend_trap_d   = bus.trap_i;
          state_d       = PEND;
        end else if (bus.imem_ready_i) begin
          // Data arrived: behaves like a normal sequential FETCH cycle
          if_id_flush = 1'b0;
          state_d     = FETCH;
          if (!bus.stall_i) begin
            pc_write    = 1'b1;
            pc_next     = pc_seq;
            if_id_write = 1'b1;
          end
        end
      end

      PEND: begin
        pending     = pend_flush_q;
        imem_req    = 1'b1;
        if_id_flush = 1'b1;
        if (pend_take_new) begin
          pend_target_d = redirect_target;
          pend_trap_d   = bus.trap_i;
        end
        if (bus.imem_ready_i) begin
          pc_write      = 1'b1;
          pc_next       = pend_take_new ? redirect_target : pend_target_q;
          if_id_write   = 1'b1;
          pend_flush_d  = 1'b0;
          pend_trap_d   = 1'b0;
          state_d       = FETCH;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase

    if (res) begin
      pc_write    = 1'b0;
      pc_next     = RESET_VECTOR;
      imem_req    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      pending     = 1'b0;
    end
  end

  assign bus.pc_write_o    = pc_write;
  assign bus.pc_next_o     = pc_next;
  assign bus.imem_req_o    = imem_req;
  assign bus.if_id_write_o = if_id_write;
  assign bus.if_id_flush_o = if_id_flush;
  assign bus.pending_o     = pending;

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Directed bench for fetch_pc_controller: inputs change on the falling edge,
// outputs are checked 1ns later, state advances on the rising edge.
module tb_fetch_pc_controller;
  logic clk;
  logic res;
  int   total;
  int   bad;

  fetch_pc_controller_if bus ();

  fetch_pc_controller dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic stall, input logic br,
                       input logic [31:0] br_t, input logic jmp, input logic [31:0] jmp_t,
                       input logic trap, input logic rdy);
    @(negedge clk);
    bus.pc_i            = pc;
    bus.stall_i         = stall;
    bus.branch_taken_i  = br;
    bus.branch_target_i = br_t;
    bus.jump_i          = jmp;
    bus.jump_target_i   = jmp_t;
    bus.trap_i          = trap;
    bus.imem_ready_i    = rdy;
    #1;
  endtask

  // Convenience: sequential cycle with the given pc / stall / ready
  task automatic seq(input logic [31:0] pc, input logic stall, input logic rdy);
    drive(pc, stall, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    res   = 1'b1;
    bus.pc_i = 32'h0; bus.stall_i = 1'b0; bus.branch_taken_i = 1'b0;
    bus.branch_target_i = 32'h0; bus.jump_i = 1'b0; bus.jump_target_i = 32'h0;
    bus.trap_i = 1'b0; bus.imem_ready_i = 1'b1;

    // Reset values
    seq(32'h0, 1'b0, 1'b1);
    chk("rst_pc_write", {31'b0, bus.pc_write_o}, 32'd0);
    chk("rst_imem_req", {31'b0, bus.imem_req_o}, 32'd0);
    chk("rst_flush", {31'b0, bus.if_id_flush_o}, 32'd1);
    chk("rst_pc_next", bus.pc_next_o, 32'h0);
    chk("rst_pending", {31'b0, bus.pending_o}, 32'd0);

    // BOOT cycle
    @(negedge clk);
    res = 1'b0;
    #1;
    chk("boot_pc_write", {31'b0, bus.pc_write_o}, 32'd1);
    chk("boot_pc_next", bus.pc_next_o, 32'h0);
    chk("boot_imem_req", {31'b0, bus.imem_req_o}, 32'd0);
    chk("boot_flush", {31'b0, bus.if_id_flush_o}, 32'd1);

    // Sequential advance 0x4, 0x8, 0xC
    seq(32'h0, 1'b0, 1'b1);
    chk("seq0_next", bus.pc_next_o, 32'h4);
    chk("seq0_flush", {31'b0, bus.if_id_flush_o}, 32'd0);
    chk("seq0_req", {31'b0, bus.imem_req_o}, 32'd1);
    seq(32'h4, 1'b0, 1'b1);
    chk("seq1_next", bus.pc_next_o, 32'h8);
    seq(32'h8, 1'b0, 1'b1);
    chk("seq2_next", bus.pc_next_o, 32'hC);
    chk("seq2_flush", {31'b0, bus.if_id_flush_o}, 32'd0);

    // Stall for 3 cycles at 0x10
    for (int i = 0; i < 3; i++) begin
      seq(32'h10, 1'b1, 1'b1);
      chk("stall_pc_write", {31'b0, bus.pc_write_o}, 32'd0);
      chk("stall_ifid_write", {31'b0, bus.if_id_write_o}, 32'd0);
    end
    seq(32'h10, 1'b0, 1'b1);
    chk("unstall_next", bus.pc_next_o, 32'h14);
    chk("unstall_write", {31'b0, bus.pc_write_o}, 32'd1);

    // Branch + jump same cycle: jump wins
    drive(32'h20, 1'b0, 1'b1, 32'h83, 1'b1, 32'h40, 1'b0, 1'b1);
    chk("bj_next", bus.pc_next_o, 32'h40);
    chk("bj_flush", {31'b0, bus.if_id_flush_o}, 32'd1);
    chk("bj_write", {31'b0, bus.pc_write_o}, 32'd1);
    // Branch only, target aligned down
    drive(32'h20, 1'b0, 1'b1, 32'h83, 1'b0, 32'h40, 1'b0, 1'b1);
    chk("br_next", bus.pc_next_o, 32'h80);

    // Branch with memory not ready for 2 cycles
    drive(32'h30, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("brw0_write", {31'b0, bus.pc_write_o}, 32'd0);
    chk("brw0_flush", {31'b0, bus.if_id_flush_o}, 32'd1);
    seq(32'h30, 1'b0, 1'b0);
    chk("brw1_pending", {31'b0, bus.pending_o}, 32'd1);
    chk("brw1_write", {31'b0, bus.pc_write_o}, 32'd0);
    seq(32'h30, 1'b0, 1'b1);
    chk("brw_ready_next", bus.pc_next_o, 32'h200);
    chk("brw_ready_write", {31'b0, bus.pc_write_o}, 32'd1);

    // Same, trap pulsed while waiting overrides the parked branch
    drive(32'h30, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(32'h30, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("trw_pending", {31'b0, bus.pending_o}, 32'd1);
    seq(32'h30, 1'b0, 1'b1);
    chk("trw_ready_next", bus.pc_next_o, 32'h100);
    // Back in FETCH, pending cleared
    seq(32'h100, 1'b0, 1'b1);
    chk("trw_after_pending", {31'b0, bus.pending_o}, 32'd0);
    chk("trw_after_next", bus.pc_next_o, 32'h104);

    // WAIT path without redirect
    seq(32'h40, 1'b0, 1'b0);
    chk("wait0_write", {31'b0, bus.pc_write_o}, 32'd0);
    chk("wait0_flush", {31'b0, bus.if_id_flush_o}, 32'd1);
    seq(32'h40, 1'b0, 1'b1);
    chk("wait1_next", bus.pc_next_o, 32'h44);
    chk("wait1_write", {31'b0, bus.pc_write_o}, 32'd1);
    chk("wait1_pending", {31'b0, bus.pending_o}, 32'd0);

    // Wraparound
    seq(32'hFFFF_FFFC, 1'b0, 1'b1);
    chk("wrap_next", bus.pc_next_o, 32'h0);
    // Trap beats stall
    drive(32'h50, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("trapstall_next", bus.pc_next_o, 32'h100);
    chk("trapstall_write", {31'b0, bus.pc_write_o}, 32'd1);

    // Reset asserted mid-cycle while in PEND
    drive(32'h60, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
    seq(32'h60, 1'b0, 1'b0);
    chk("pre_rst_pending", {31'b0, bus.pending_o}, 32'd1);
    res = 1'b1;
    #1;
    chk("arst_pending", {31'b0, bus.pending_o}, 32'd0);
    chk("arst_req", {31'b0, bus.imem_req_o}, 32'd0);
    chk("arst_flush", {31'b0, bus.if_id_flush_o}, 32'd1);
    chk("arst_next", bus.pc_next_o, 32'h0);
    seq(32'h60, 1'b0, 1'b1);
    chk("arst_hold_write", {31'b0, bus.pc_write_o}, 32'd0);
    @(negedge clk);
    res = 1'b0;
    #1;
    chk("reboot_write", {31'b0, bus.pc_write_o}, 32'd1);
    chk("reboot_next", bus.pc_next_o, 32'h0);
    seq(32'h0, 1'b0, 1'b1);
    chk("reboot_seq_next", bus.pc_next_o, 32'h4);
    chk("reboot_pending", {31'b0, bus.pending_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
